// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative integer multiply / divide unit. A request is accepted in IDLE,
//   the operands are reduced to magnitudes, WIDTH shift-add (multiply) or
//   restoring shift-subtract (divide) iterations run in CALC, and FIX applies
//   the sign correction and commits the result to hi/lo with a done pulse.
//
//   Build option:
//     MULDIV_DIV0_FLAG_EN  defined   -> DIV/DIVU with b == 0 skip CALC, keep
//                                       hi/lo and raise div0 with done.
//                          undefined -> div0 tied low; divide by zero runs the
//                                       full iteration count and yields the
//                                       natural restoring-divider result.
//
//   Ports:
//     clk    in   clock, all state changes on rising edge
//     rstn   in   asynchronous active-low reset
//     start  in   request, sampled only in IDLE
//     op     in   [1:0] 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     a      in   [WIDTH-1:0] multiplicand / dividend
//     b      in   [WIDTH-1:0] multiplier / divisor
//     flush  in   synchronous abort of an in-flight operation
//     busy   out  operation in flight
//     done   out  one-cycle pulse, hi/lo updated
//     hi     out  [WIDTH-1:0] product upper half / remainder
//     lo     out  [WIDTH-1:0] product lower half / quotient
//     div0   out  divide-by-zero flag (see build option)
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             op_div_r;     // 1: divide, 0: multiply
    logic             res_neg_r;    // product / quotient must be negated
    logic             rem_neg_r;    // remainder must be negated
    logic [WIDTH-1:0] m_r;          // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi_r;     // partial product high / partial remainder
    logic [WIDTH-1:0] acc_lo_r;     // multiplier-shift / dividend-quotient shift
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;
    logic             busy_r;
`ifdef MULDIV_DIV0_FLAG_EN
    logic             div0_r;
    logic             div0_pend_r;  // this operation was a divide by zero
    logic             div0_hit_s;
`endif

    // Acceptance-time operand conditioning
    logic             signed_op_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH-1:0] load_m_s;
    logic [WIDTH-1:0] load_lo_s;

    // One iteration step
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH+1:0]   div_diff_s;
    logic               div_ok_s;
    logic [WIDTH-1:0]   step_hi_s;
    logic [WIDTH-1:0]   step_lo_s;

    // Sign correction
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    // Operand magnitudes and load values for a new request
    always_comb begin
        signed_op_s = ~op[0];
        a_neg_s     = signed_op_s & a[WIDTH-1];
        b_neg_s     = signed_op_s & b[WIDTH-1];
        a_mag_s     = a;
        b_mag_s     = b;
        if (a_neg_s) begin
            a_mag_s = ~a + ONE_W;
        end else begin
            a_mag_s = a;
        end
        if (b_neg_s) begin
            b_mag_s = ~b + ONE_W;
        end else begin
            b_mag_s = b;
        end
        // Divide keeps the divisor in m_r and shifts the dividend out of the
        // low register; multiply keeps the multiplicand and shifts the
        // multiplier.
        if (op[1]) begin
            load_m_s  = b_mag_s;
            load_lo_s = a_mag_s;
        end else begin
            load_m_s  = a_mag_s;
            load_lo_s = b_mag_s;
        end
    end

`ifdef MULDIV_DIV0_FLAG_EN
    // Divide-by-zero detection at acceptance
    always_comb begin
        div0_hit_s = op[1] & (b == ZERO_W);
    end
`endif

    // Single iteration of shift-add multiply or restoring divide
    always_comb begin
        // Multiply: add multiplicand when the current multiplier bit is set,
        // then shift the whole {carry, hi, lo} right by one.
        mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, m_r} : {(WIDTH+1){1'b0}});
        // Divide: bring the next dividend bit into the partial remainder and
        // try to subtract the divisor; the extra top bit is the borrow.
        div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, m_r};
        div_ok_s    = ~div_diff_s[WIDTH+1];
        if (op_div_r) begin
            if (div_ok_s) begin
                step_hi_s = div_diff_s[WIDTH-1:0];
            end else begin
                step_hi_s = div_shift_s[WIDTH-1:0];
            end
            step_lo_s = {acc_lo_r[WIDTH-2:0], div_ok_s};
        end else begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end
    end

    // Sign correction of the raw magnitude result
    always_comb begin
        prod_s = {acc_hi_r, acc_lo_r};
        if (res_neg_r) begin
            prod_fix_s = ~prod_s + ONE_2W;
            quo_fix_s  = ~acc_lo_r + ONE_W;
        end else begin
            prod_fix_s = prod_s;
            quo_fix_s  = acc_lo_r;
        end
        if (rem_neg_r) begin
            rem_fix_s = ~acc_hi_r + ONE_W;
        end else begin
            rem_fix_s = acc_hi_r;
        end
        if (op_div_r) begin
            fix_hi_s = rem_fix_s;
            fix_lo_s = quo_fix_s;
        end else begin
            fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            op_div_r    <= 1'b0;
            res_neg_r   <= 1'b0;
            rem_neg_r   <= 1'b0;
            m_r         <= ZERO_W;
            acc_hi_r    <= ZERO_W;
            acc_lo_r    <= ZERO_W;
            hi_r        <= ZERO_W;
            lo_r        <= ZERO_W;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
            div0_r      <= 1'b0;
            div0_pend_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
            div0_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    // flush in IDLE blocks a simultaneous start
                    if (start && !flush) begin
                        op_div_r  <= op[1];
                        res_neg_r <= a_neg_s ^ b_neg_s;
                        rem_neg_r <= a_neg_s;
                        m_r       <= load_m_s;
                        acc_hi_r  <= ZERO_W;
                        acc_lo_r  <= load_lo_s;
                        cnt_r     <= CNT_LOAD;
                        busy_r    <= 1'b1;
`ifdef MULDIV_DIV0_FLAG_EN
                        if (div0_hit_s) begin
                            state_r     <= ST_FIX;
                            div0_pend_r <= 1'b1;
                        end else begin
                            state_r     <= ST_CALC;
                            div0_pend_r <= 1'b0;
                        end
`else
                        state_r   <= ST_CALC;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        acc_hi_r <= step_hi_s;
                        acc_lo_r <= step_lo_s;
                        cnt_r    <= cnt_r - CNT_ONE;
                        if (cnt_r == CNT_ONE) begin
                            state_r <= ST_FIX;
                        end else begin
                            state_r <= ST_CALC;
                        end
                    end
                end
                ST_FIX: begin
                    if (flush) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
`ifdef MULDIV_DIV0_FLAG_EN
                        if (div0_pend_r) begin
                            div0_r <= 1'b1;
                        end else begin
                            hi_r <= fix_hi_s;
                            lo_r <= fix_lo_s;
                        end
                        div0_pend_r <= 1'b0;
`else
                        hi_r <= fix_hi_s;
                        lo_r <= fix_lo_s;
`endif
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;
`ifdef MULDIV_DIV0_FLAG_EN
    assign div0 = div0_r;
`else
    assign div0 = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Scoreboard bench for muldiv_unit (WIDTH=32). Stimulus pushes the expected
//   result and completion cycle at issue time; an independent monitor pops
//   and compares on every done pulse, and checks that hi/lo hold otherwise.
//   The reference model uses plain 64-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .div0  (div0)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         div0;
        logic [31:0]  cyc;
        logic [W-1:0] prev_hi;
        logic [W-1:0] prev_lo;
    } exp_t;

    exp_t         exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;
    logic [W-1:0] mon_hi   = '0;
    logic [W-1:0] mon_lo   = '0;

    // edge counter used for latency expectations
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: result from the arithmetic definition of each op.
    function automatic exp_t ref_model(input logic [1:0] o, input logic [W-1:0] x,
                                       input logic [W-1:0] y, input logic [W-1:0] ph,
                                       input logic [W-1:0] pl, input int issue_cyc);
        exp_t               e;
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] q;
        logic signed [63:0] r;
        logic [63:0]        p;
        logic [63:0]        ux;
        logic [63:0]        uy;
        sx = {{W{x[W-1]}}, x};
        sy = {{W{y[W-1]}}, y};
        ux = {{W{1'b0}}, x};
        uy = {{W{1'b0}}, y};
        e.prev_hi = ph;
        e.prev_lo = pl;
        e.div0    = 1'b0;
        e.cyc     = issue_cyc + W + 2;
        e.hi      = '0;
        e.lo      = '0;
        case (o)
            2'b00: begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = ux * uy; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b10: begin
                if (y == '0) begin
`ifdef MULDIV_DIV0_FLAG_EN
                    e.hi = ph; e.lo = pl; e.div0 = 1'b1; e.cyc = issue_cyc + 2;
`else
                    e.hi = x;
                    e.lo = (sx < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF;
`endif
                end else begin
                    q = sx / sy; r = sx % sy;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end
            end
            default: begin
                if (y == '0) begin
`ifdef MULDIV_DIV0_FLAG_EN
                    e.hi = ph; e.lo = pl; e.div0 = 1'b1; e.cyc = issue_cyc + 2;
`else
                    e.hi = x; e.lo = 32'hFFFF_FFFF;
`endif
                end else begin
                    p = ux / uy; e.lo = p[31:0];
                    p = ux % uy; e.hi = p[31:0];
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            6: return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compare on done, check hold otherwise
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                mon_hi = '0;
                mon_lo = '0;
            end else if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no completion (cyc=%0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                    check("hi", 64'(hi), 64'(e.hi));
                    check("lo", 64'(lo), 64'(e.lo));
                    check("div0", 64'(div0), 64'(e.div0));
                    check("busy_at_done", 64'(busy), 64'd0);
                    mon_hi = e.hi;
                    mon_lo = e.lo;
                end
            end else begin
                check("hold_hi", 64'(hi), 64'(mon_hi));
                check("hold_lo", 64'(lo), 64'(mon_lo));
                check("div0_low", 64'(div0), 64'd0);
            end
        end
    end

    // Wait for idle (optionally pulsing ignored starts), then issue one op.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit noise);
        int   guard;
        exp_t e;
        guard = 0;
        @(posedge clk); #1;
        while (busy && guard < 500) begin
            if (noise) begin
                start = ($urandom_range(0, 3) == 0);
                op    = 2'($urandom);
                a     = $urandom;
                b     = $urandom;
            end
            @(posedge clk); #1;
            guard++;
        end
        if (busy) begin
            check("issue_timeout_busy", 64'(busy), 64'd0);
            start = 1'b0;
            return;
        end
        start = 1'b1; op = o; a = x; b = y;
        e = ref_model(o, x, y, model_hi, model_lo, cyc);
        exp_q.push_back(e);
        model_hi = e.hi;
        model_lo = e.lo;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout_pending", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic count_busy(input string name, input int expv);
        int n;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check(name, 64'(n), 64'(expv));
    endtask

    task automatic cancel_last();
        exp_t e;
        e = exp_q.pop_back();
        model_hi = e.prev_hi;
        model_lo = e.prev_lo;
    endtask

    initial begin
        exp_t e1;
        exp_t e2;
        rstn = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_div0", 64'(div0), 64'd0);
        rstn = 1'b1;

        // Directed vectors
        issue(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        count_busy("busy_cycles_mult", W + 1);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(2'b11, 32'd100, 32'd0, 1'b0);
`ifdef MULDIV_DIV0_FLAG_EN
        count_busy("busy_cycles_div0", 1);
`else
        count_busy("busy_cycles_div0", W + 1);
`endif
        issue(2'b10, 32'hFFFF_FF9C, 32'd0, 1'b0);
        wait_idle();

        // Flush during CALC; second start while busy is ignored
        issue(2'b11, 32'd10, 32'd3, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b1; op = 2'b00; a = 32'd1234; b = 32'd77;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        cancel_last();
        check("busy_after_flush_calc", 64'(busy), 64'd0);
        repeat (W + 10) begin @(posedge clk); #1; end

        // Flush in FIX
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (W) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        cancel_last();
        check("busy_after_flush_fix", 64'(busy), 64'd0);
        repeat (5) begin @(posedge clk); #1; end

        // flush with start in IDLE: nothing accepted
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("busy_flush_idle", 64'(busy), 64'd0);
        repeat (W + 5) begin @(posedge clk); #1; end

        // Back-to-back: start held high across done
        e1 = ref_model(2'b01, 32'hDEAD_BEEF, 32'h0000_1000, model_hi, model_lo, cyc);
        start = 1'b1; op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h0000_1000;
        exp_q.push_back(e1); model_hi = e1.hi; model_lo = e1.lo;
        @(posedge clk); #1;
        op = 2'b10; a = 32'hFFFF_F000; b = 32'h0000_0007;
        e2 = ref_model(2'b10, 32'hFFFF_F000, 32'h0000_0007, model_hi, model_lo, cyc + W + 1);
        exp_q.push_back(e2); model_hi = e2.hi; model_lo = e2.lo;
        repeat (W + 1) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_b2b_second", 64'(busy), 64'd1);
        wait_idle();

        // Randomized traffic with ignored start pulses while busy
        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick(), 1'b1);
        end
        wait_idle();

        // Reset mid-operation
        issue(2'b01, $urandom, $urandom, 1'b0);
        repeat (19) begin @(posedge clk); #1; end
        rstn = 1'b0;
        #1;
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        model_hi = '0;
        model_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (W + 10) begin @(posedge clk); #1; end
        check("post_rst_busy", 64'(busy), 64'd0);

        // One more op after reset to confirm recovery
        issue(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        wait_idle();
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
- REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal values >= 4.
- REQ-002 clk  input  1  single clock; all state changes on its rising edge.
- REQ-003 rstn  input  1  reset, asynchronous assert, active-low.
- REQ-004 start  input  1  request; sampled only in IDLE.
- REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- REQ-006 a  input  WIDTH  multiplicand or dividend.
- REQ-007 b  input  WIDTH  multiplier or divisor.
- REQ-008 flush  input  1  synchronous abort of an in-flight operation.
- REQ-009 busy  output  1  high while an operation is in flight.
- REQ-010 done  output  1  one-cycle pulse: hi/lo updated.
- REQ-011 hi  output  WIDTH  product upper half, or remainder.
- REQ-012 lo  output  WIDTH  product lower half, or quotient.
- REQ-013 div0  output  1  divide-by-zero flag; see Configuration.

Function
- REQ-014 States: IDLE, CALC, FIX; reset enters IDLE.
- REQ-015 IDLE with start=1 at edge k: latch a, b, op into internal registers; convert signed operands to magnitudes; load iteration counter with WIDTH; go to CALC.
- REQ-016 CALC: one iteration per clock; multiply is shift-add, divide is restoring shift-subtract; counter decrements; counter reaching 0 moves to FIX.
- REQ-017 FIX, one cycle: apply sign correction; write hi/lo; pulse done; return to IDLE.
- REQ-018 Latency: busy=1 for cycles k+1 through k+WIDTH+1; done=1 and new hi/lo visible in cycle k+WIDTH+2, when busy=0.
- REQ-019 A new start is accepted in the same cycle done is high.
- REQ-020 start while busy=1 is ignored; no queueing.
- REQ-021 The unit reads a, b and op only at acceptance; later changes to these inputs have no effect.
- REQ-022 MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, signed and unsigned respectively.
- REQ-023 DIV: quotient truncates toward zero; remainder sign equals dividend sign.
- REQ-024 DIVU: unsigned quotient and remainder.
- REQ-025 DIV of the most-negative value by -1: lo = most-negative value (wraps); hi = 0; no flag.
- REQ-026 hi/lo hold their value between completions; flush and reject never alter them.
- REQ-027 flush=1 in CALC or FIX: next state IDLE; busy=0 next cycle; no done pulse.
- REQ-028 flush=1 in IDLE: no effect, even when start=1 in the same cycle; flush has priority over start.

Reset
- REQ-029 rstn=0 asynchronously forces IDLE, busy=0, done=0, div0=0, hi=0, lo=0, and clears counter and internal registers.
- REQ-030 Reset mid-operation discards that operation; no done pulse follows deassertion.

Configuration
- REQ-031 Macro MULDIV_DIV0_FLAG_EN.
- REQ-032 Macro defined, DIV/DIVU accepted with b=0:
  - skip CALC; go straight to FIX; done pulses in cycle k+2;
  - hi/lo unchanged;
  - div0=1 for the done cycle only.
- REQ-033 Macro undefined:
  - div0 tied to 0;
  - divide by zero runs full latency;
  - DIVU result: lo = all ones, hi = a;
  - DIV result: hi = a; lo = 1 when a is negative, else all ones.

Verification (WIDTH=32)
- REQ-034 MULT a=0xFFFFFFFE (-2), b=3 -> done at cycle k+34; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high cycles k+1..k+33.
- REQ-035 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- REQ-036 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- REQ-037 DIVU a=100, b=0:
  - with macro: done at k+2, div0=1, hi/lo unchanged;
  - without macro: done at k+34, lo=0xFFFFFFFF, hi=100.
- REQ-038 Start DIVU 10/3; pulse start again at k+5 with different operands; flush at k+10 -> second start ignored; no done; busy=0 at k+11; hi/lo unchanged.
- REQ-039 Start MULTU; drive rstn=0 at k+20 for 2 cycles -> hi=lo=0 and busy=0 immediately; no done afterward. Back-to-back: start held high across done -> second operation accepted in the done cycle.
